load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the multicycle RV32I core datapath and the word-organised data memory. Accepts one load or store per handshake and, for each request:
- aligns the address to a word;
- generates byte-lane write masks and replicated store data;
- waits a parameterised memory read latency;
- sign- or zero-extends the returned byte/halfword;
- returns a single-cycle response with a fault flag.

## Interface
Parameters:
- MEM_LATENCY, default 1: cycles from the memory sampling an address to valid mem_rdata. Legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_fault  output  1  request rejected, qualified by resp_valid
- mem_address  output  32  word-aligned address, low 2 bits always 0
- mem_wren  output  1  write strobe
- mem_wmask  output  4  byte-lane enables; bit n covers bits [8n+7:8n]
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read word

## Operation
- Request fields are latched on the accept edge (req_valid & req_ready). Later changes on req_* are ignored.
- States and transitions:
  - IDLE -> RESP on a faulting request, with no memory access.
  - IDLE -> ISSUE on any other request.
  - ISSUE -> RESP for stores.
  - ISSUE -> WAIT for loads.
  - WAIT -> RESP when the latency counter expires.
  - RESP -> IDLE unconditionally.
- ISSUE:
  - mem_address = {addr[31:2],2'b00}.
  - For stores, mem_wren=1 for exactly this cycle.
  - SB: mem_wmask = 1<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_wmask = 4'b0011 or 4'b1100 selected by addr[1]; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_wmask = 4'b1111; mem_wdata = wdata.
- WAIT:
  - The counter loads MEM_LATENCY at ISSUE and decrements each cycle.
  - In the cycle the counter is 1, mem_rdata is valid and is captured.
  - Captured data is shifted right by 8*addr[1:0].
  - Sign-extended for funct3 000 (bit 7) and 001 (bit 15); zero-extended for 100 and 101; passed unmodified for 010.
- RESP: resp_valid=1 for one cycle; resp_rdata and resp_fault hold the registered result.
- Illegal funct3 always faults: loads 011/110/111, stores 011 and above.
- mem_address and mem_wdata hold their last value outside ISSUE/WAIT. mem_wren and mem_wmask are 0 outside ISSUE.

## Timing
- Reset values of outputs: req_ready=0 while reset_n is low, then 1 (IDLE). resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_wren=0, mem_wmask=0, mem_wdata=0.
- Latency, counted from the accept edge to the resp_valid cycle:
  - fault: 1 cycle;
  - store: 2 cycles;
  - load: MEM_LATENCY+2 cycles.
- Throughput: the next accept is possible in the cycle after RESP. req_ready=0 from ISSUE through RESP.
- Reset asserted mid-operation:
  - all state clears immediately, including mem_wren;
  - the in-flight store may be lost;
  - no resp_valid is produced for the aborted request.
- A req_valid held high across RESP is accepted on the first IDLE cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword accesses with addr[0]=1 fault; word accesses with addr[1:0]≠0 fault.
  - A faulting access performs no memory access and mem_wren stays 0.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned addresses are force-aligned: halfword clears addr[0], word clears addr[1:0].
  - The access proceeds with resp_fault=0.
  - Only illegal funct3 faults.

## Test plan
- Loads, memory word 0x2000 = 0x8070F0A5, MEM_LATENCY=1:
  - LB 0x2000 -> 0xFFFFFFA5;
  - LBU 0x2001 -> 0x000000F0;
  - LH 0x2002 -> 0xFFFF8070;
  - LHU 0x2002 -> 0x00008070;
  - LW 0x2000 -> 0x8070F0A5;
  - each with resp_valid 3 cycles after accept.
- SB 0x2003, wdata 0x000000CC -> one-cycle mem_wren, mem_address=0x2000, mem_wmask=4'b1000, mem_wdata=0xCCCCCCCC; resp_valid 2 cycles after accept, resp_rdata=0.
- LW 0x2002:
  - with the macro -> resp_fault=1 one cycle after accept, no mem_wren, resp_rdata=0;
  - without -> reads 0x2000 and returns 0x8070F0A5, resp_fault=0.
- Load with funct3=3'b011 -> resp_fault=1 after 1 cycle; store with funct3=3'b100 -> resp_fault=1, mem_wren never asserted.
- MEM_LATENCY=3, LW 0x2000 -> resp_valid exactly 5 cycles after accept; req_ready low for the whole period.
- reset_n pulsed low during WAIT -> outputs return to reset values immediately, no resp_valid, req_ready=1 the cycle after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: load/store unit between the RV32I multicycle core and a
// word-organised data memory. It accepts one request per handshake, drives
// word-aligned memory accesses with byte-lane masks, waits MEM_LATENCY cycles
// for read data, extends the returned byte or halfword and issues a one-cycle
// response.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses. Without it, misaligned addresses are force-aligned.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1  // legal range 1..4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic        mem_wren,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        accept;
  logic        req_fault;
  logic [1:0]  req_offset;
  logic [3:0]  req_mask;
  logic [31:0] req_lane_data;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [3:0]  mask_q;
  logic [2:0]  cnt_q;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  assign accept = req_valid & req_ready;

  // Classify the incoming request: illegal funct3 (and, optionally, misalignment) faults.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    req_fault = 1'b0;
    if (req_we) begin
      req_fault = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      req_fault = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01) req_fault = req_fault | req_addr[0];
    if (req_funct3[1:0] == 2'b10) req_fault = req_fault | (|req_addr[1:0]);
`endif
  end

  // Effective byte offset, lane mask and replicated store data for the request.
  // Misaligned halfword/word offsets are force-aligned here; with the trap
  // enabled those requests have already faulted and never reach memory.
  always_comb begin
    req_offset    = 2'b00;
    req_mask      = 4'b1111;
    req_lane_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_offset    = req_addr[1:0];
        req_mask      = 4'b0001 << req_addr[1:0];
        req_lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_offset    = {req_addr[1], 1'b0};
        req_mask      = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        req_offset    = 2'b00;
        req_mask      = 4'b1111;
        req_lane_data = req_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = req_fault ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == 3'd1) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Right-justify the captured word and extend it according to the load type.
  always_comb begin
    load_shifted = mem_rdata >> {offset_q, 3'b000};
    load_ext     = load_shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shifted[7]}},  load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = {24'h0, load_shifted[7:0]};
      3'b101:  load_ext = {16'h0, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Request latch, latency counter, memory address/data and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      mask_q      <= 4'b0000;
      cnt_q       <= 3'd0;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
      resp_rdata  <= 32'h0;
      resp_fault  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            offset_q   <= req_offset;
            resp_rdata <= 32'h0;
            resp_fault <= req_fault;
            // A faulting request makes no memory access, so the bus keeps its last value.
            if (!req_fault) begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (req_we) begin
                mask_q    <= req_mask;
                mem_wdata <= req_lane_data;
              end
            end
          end
        end
        S_ISSUE: cnt_q <= 3'(MEM_LATENCY);
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) resp_rdata <= load_ext;
        end
        default: ;
      endcase
    end
  end

  // Write strobe and mask decode straight from the state, so reset drops them at once.
  assign mem_wren   = (state == S_ISSUE) & we_q;
  assign mem_wmask  = mem_wren ? mask_q : 4'b0000;
  assign req_ready  = (state == S_IDLE) & reset_n;
  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table-driven directed requests against a
// MEM_LATENCY=1 instance, plus hand sequences for back-to-back requests,
// a MEM_LATENCY=3 instance and reset during WAIT.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        valid1, ready1, rvalid1, rfault1, wren1;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
  logic [3:0]  mask1;
  logic        valid3, ready3, rvalid3, rfault3, wren3;
  logic [31:0] rdata3, maddr3, mwdata3, mrdata3;
  logic [3:0]  mask3;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_fault(rfault1),
    .mem_address(maddr1), .mem_wren(wren1), .mem_wmask(mask1), .mem_wdata(mwdata1),
    .mem_rdata(mrdata1)
  );

  load_store_unit #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid3), .resp_rdata(rdata3), .resp_fault(rfault3),
    .mem_address(maddr3), .mem_wren(wren3), .mem_wmask(mask3), .mem_wdata(mwdata3),
    .mem_rdata(mrdata3)
  );

  // Shared word memory with per-instance read pipelines of the matching latency.
  logic [31:0] mem [16] = '{0: 32'h8070F0A5, default: 32'h0};
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1    <= mem[maddr1[5:2]];
    pipe3[0] <= mem[maddr3[5:2]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    for (int b = 0; b < 4; b++) begin
      if (wren1 && mask1[b]) mem[maddr1[5:2]][8*b +: 8] <= mwdata1[8*b +: 8];
      if (wren3 && mask3[b]) mem[maddr3[5:2]][8*b +: 8] <= mwdata3[8*b +: 8];
    end
  end
  assign mrdata1 = pipe1;
  assign mrdata3 = pipe3[2];

  // Selected-instance view used by the request task.
  logic        sel;
  logic        o_ready, o_rvalid, o_rfault, o_wren;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_mask;
  assign o_ready  = sel ? ready3  : ready1;
  assign o_rvalid = sel ? rvalid3 : rvalid1;
  assign o_rfault = sel ? rfault3 : rfault1;
  assign o_wren   = sel ? wren3   : wren1;
  assign o_rdata  = sel ? rdata3  : rdata1;
  assign o_addr   = sel ? maddr3  : maddr1;
  assign o_wdata  = sel ? mwdata3 : mwdata1;
  assign o_mask   = sel ? mask3   : mask1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          wrens;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs [17];

  // Issue one request on the selected instance and check the whole transaction.
  task automatic run_req(input vec_t v);
    int          n;
    int          waited;
    int          wren_cnt;
    bit          got;
    bit          ready_low;
    logic [31:0] issue_addr;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    if (sel) valid3 = 1'b1; else valid1 = 1'b1;
    waited = 0;
    while (!o_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({v.name, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    // Scramble the request fields; the unit must use its latched copy.
    req_addr   = 32'hFFFF_FFFF;
    req_funct3 = 3'b111;
    req_wdata  = 32'h5A5A_5A5A;
    n = 1; got = 0; wren_cnt = 0; ready_low = 1;
    issue_addr = o_addr; w_addr = 0; w_data = 0; w_mask = 0;
    while (n <= 12) begin
      if (o_wren) begin
        wren_cnt++;
        w_addr = o_addr; w_data = o_wdata; w_mask = o_mask;
      end
      if (o_ready) ready_low = 0;
      if (o_rvalid) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check({v.name, "_latency"}, 32'(n), 32'(v.lat));
    check({v.name, "_rdata"}, o_rdata, v.rdata);
    check({v.name, "_fault"}, 32'(o_rfault), 32'(v.fault));
    check({v.name, "_wren_count"}, 32'(wren_cnt), 32'(v.wrens));
    check({v.name, "_ready_low"}, 32'(ready_low), 32'd1);
    if (!v.fault && !v.we) check({v.name, "_mem_address"}, issue_addr, v.maddr);
    if (!v.fault && v.we) begin
      check({v.name, "_st_address"}, w_addr, v.maddr);
      check({v.name, "_st_mask"}, 32'(w_mask), 32'(v.mask));
      check({v.name, "_st_wdata"}, w_data, v.mwdata);
    end
    @(posedge clk); #1;
    check({v.name, "_pulse_end"}, 32'(o_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit   seen;
    vec_t v3;

    vecs[0]  = '{"lb",    0, 3'b000, 32'h2000, 32'h0, 32'hFFFFFFA5, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[1]  = '{"lbu",   0, 3'b100, 32'h2001, 32'h0, 32'h000000F0, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[2]  = '{"lh",    0, 3'b001, 32'h2002, 32'h0, 32'hFFFF8070, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[3]  = '{"lhu",   0, 3'b101, 32'h2002, 32'h0, 32'h00008070, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[4]  = '{"lw",    0, 3'b010, 32'h2000, 32'h0, 32'h8070F0A5, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[5]  = '{"lw_mis", 0, 3'b010, 32'h2002, 32'h0, 32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{"lh_mis", 0, 3'b001, 32'h2003, 32'h0, 32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0};
`else
    vecs[5]  = '{"lw_mis", 0, 3'b010, 32'h2002, 32'h0, 32'h8070F0A5, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[6]  = '{"lh_mis", 0, 3'b001, 32'h2003, 32'h0, 32'hFFFF8070, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
`endif
    vecs[7]  = '{"ld_bad", 0, 3'b011, 32'h2000, 32'h0, 32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0};
    vecs[8]  = '{"st_bad", 1, 3'b100, 32'h2000, 32'h11223344, 32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{"sb",    1, 3'b000, 32'h2003, 32'h000000CC, 32'h0, 0, 2, 1, 32'h2000, 4'b1000, 32'hCCCCCCCC};
    vecs[10] = '{"sh",    1, 3'b001, 32'h2006, 32'hABCD1234, 32'h0, 0, 2, 1, 32'h2004, 4'b1100, 32'h12341234};
    vecs[11] = '{"sw",    1, 3'b010, 32'h2008, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h2008, 4'b1111, 32'hDEADBEEF};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[12] = '{"sw_mis", 1, 3'b010, 32'h200B, 32'hCAFEF00D, 32'h0, 1, 1, 0, 32'h0, 4'h0, 32'h0};
`else
    vecs[12] = '{"sw_mis", 1, 3'b010, 32'h200B, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'h2008, 4'b1111, 32'hCAFEF00D};
`endif
    vecs[13] = '{"lw_after_sb", 0, 3'b010, 32'h2000, 32'h0, 32'hCC70F0A5, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[14] = '{"lb_neg",  0, 3'b000, 32'h2003, 32'h0, 32'hFFFFFFCC, 0, 3, 0, 32'h2000, 4'h0, 32'h0};
    vecs[15] = '{"lw_sh",   0, 3'b010, 32'h2004, 32'h0, 32'h12340000, 0, 3, 0, 32'h2004, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[16] = '{"lbu_hi",  0, 3'b100, 32'h200A, 32'h0, 32'h000000AD, 0, 3, 0, 32'h2008, 4'h0, 32'h0};
`else
    vecs[16] = '{"lbu_hi",  0, 3'b100, 32'h200A, 32'h0, 32'h000000FE, 0, 3, 0, 32'h2008, 4'h0, 32'h0};
`endif

    sel        = 1'b0;
    valid1     = 1'b0;
    valid3     = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    reset_n    = 1'b0;

    // Reset values.
    #2;
    check("rst_ready", 32'(ready1), 32'd0);
    check("rst_resp_valid", 32'(rvalid1), 32'd0);
    check("rst_resp_rdata", rdata1, 32'h0);
    check("rst_resp_fault", 32'(rfault1), 32'd0);
    check("rst_mem_address", maddr1, 32'h0);
    check("rst_mem_wren", 32'(wren1), 32'd0);
    check("rst_mem_wmask", 32'(mask1), 32'd0);
    check("rst_mem_wdata", mwdata1, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(ready1), 32'd1);

    // Directed vectors on the MEM_LATENCY=1 instance.
    for (int i = 0; i < 17; i++) run_req(vecs[i]);

    // req_valid held across RESP is accepted on the first IDLE cycle.
    req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h2000;
    valid1 = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_resp", 32'(rvalid1), 32'd1);
    check("b2b_ready_in_resp", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(ready1), 32'd1);
    @(posedge clk); #1;
    check("b2b_second_resp", 32'(rvalid1), 32'd1);
    check("b2b_second_fault", 32'(rfault1), 32'd1);
    valid1 = 1'b0;
    @(posedge clk); #1;

    // MEM_LATENCY=3 load.
    sel = 1'b1;
    v3 = '{"lw_lat3", 0, 3'b010, 32'h2000, 32'h0, 32'hCC70F0A5, 0, 5, 0, 32'h2000, 4'h0, 32'h0};
    run_req(v3);

    // Reset during WAIT on the MEM_LATENCY=3 instance.
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2004;
    valid3 = 1'b1;
    @(posedge clk); #1;
    valid3 = 1'b0;
    @(posedge clk); #1;
    check("mid_wait_address", maddr3, 32'h2004);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready3), 32'd0);
    check("abort_resp_valid", 32'(rvalid3), 32'd0);
    check("abort_resp_rdata", rdata3, 32'h0);
    check("abort_mem_address", maddr3, 32'h0);
    check("abort_mem_wren", 32'(wren3), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(ready3), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (rvalid3) seen = 1;
      @(posedge clk); #1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
